prog_mem_loader: RTL and testbench

//  Parametrised program memory for the CPU datapath: synchronous-read word memory plus a byte-stream

---
 rtl/prog_mem_loader_pkg.sv | 12 +
 rtl/prog_mem_loader_byte_packer.sv | 53 +++++
 rtl/prog_mem_loader.sv | 144 ++++++++++++++
 tb/tb_prog_mem_loader.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_loader_pkg.sv
// Shared definitions for the program memory loader: loader FSM states and the byte width of the host link.
package prog_mem_loader_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/prog_mem_loader_byte_packer.sv
// Assembles little-endian host bytes into memory words; strobes a write on a full word or on the
// image's final byte, in which case the unfilled upper bytes are zero.
module prog_mem_loader_byte_packer
    import prog_mem_loader_pkg::*;
#(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              byte_vld,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic              byte_last,
    output logic [DWIDTH-1:0] word_out,
    output logic              word_wr,
    output logic              word_flush
);

    localparam int BYTES = DWIDTH / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0]  byte_cnt;
    logic [DWIDTH-1:0] asm_q;
    logic              word_full;

    assign word_full  = (byte_cnt == CNT_W'(BYTES - 1));
    assign word_wr    = byte_vld && (word_full || byte_last);
    assign word_flush = byte_vld && byte_last;

    // asm_q only ever holds the lower, already-received bytes; the rest stay zero
    always_comb begin
        word_out = asm_q;
        for (int k = 0; k < BYTES; k++) begin
            if (byte_cnt == CNT_W'(k)) begin
                word_out[k*BYTE_W +: BYTE_W] = byte_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (clear || word_wr) begin
            byte_cnt <= '0;
            asm_q    <= '0;
        end else if (byte_vld) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            asm_q    <= word_out;
        end
    end

endmodule

// File: rtl/prog_mem_loader.sv
// Run-time loadable program memory: byte-stream loader FSM writing a synchronous-read word memory,
// with a 1- or 2-cycle read pipeline toward instruction fetch.
module prog_mem_loader
    import prog_mem_loader_pkg::*;
#(
    parameter int DWIDTH  = 16,
    parameter int AWIDTH  = 12,
    parameter int DEPTH   = 1 << AWIDTH,
    parameter int OUT_REG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [BYTE_W-1:0] ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              load_done,
    output logic [AWIDTH:0]   ld_words,
    input  logic              rd_en,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic [DWIDTH-1:0] rd_dout,
    output logic              rd_valid
);

    logic [DWIDTH-1:0] mem [DEPTH];

    state_t            state;
    logic [AWIDTH-1:0] wptr;
    logic              byte_acc;
    logic              word_wr;
    logic              word_flush;
    logic [DWIDTH-1:0] word;
    logic              rd_acc;
    logic [DWIDTH-1:0] dat_p1;
    logic              vld_p1;

    // a byte arriving with load_start belongs to the abandoned image and is dropped
    assign byte_acc = ld_valid && ld_ready && !load_start;

    prog_mem_loader_byte_packer #(
        .DWIDTH (DWIDTH)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (load_start),
        .byte_vld   (byte_acc),
        .byte_in    (ld_byte),
        .byte_last  (ld_last),
        .word_out   (word),
        .word_wr    (word_wr),
        .word_flush (word_flush)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            wptr      <= '0;
            ld_words  <= '0;
            ld_ready  <= 1'b0;
            load_done <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (load_start) begin
                        state     <= ST_LOAD;
                        wptr      <= '0;
                        ld_words  <= '0;
                        ld_ready  <= 1'b1;
                        load_done <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_start) begin
                        wptr     <= '0;
                        ld_words <= '0;
                    end else if (word_wr) begin
                        wptr     <= wptr + AWIDTH'(1);
                        ld_words <= ld_words + (AWIDTH+1)'(1);
                        // the last memory word closes the image; there is no wrap-around
                        if (word_flush || wptr == AWIDTH'(DEPTH - 1)) begin
                            state     <= ST_DONE;
                            ld_ready  <= 1'b0;
                            load_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    ld_ready  <= 1'b0;
                    load_done <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (word_wr) begin
            mem[wptr] <= word;
        end
    end

    assign rd_acc = rd_en && (state != ST_LOAD);

    // stage p1: array read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dat_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= rd_acc;
            if (rd_acc) begin
                dat_p1 <= mem[rd_addr];
            end
        end
    end

    // stage p2: optional output register
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] dat_p2;
            logic              vld_p2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dat_p2 <= '0;
                    vld_p2 <= 1'b0;
                end else begin
                    vld_p2 <= vld_p1;
                    if (vld_p1) begin
                        dat_p2 <= dat_p1;
                    end
                end
            end

            assign rd_dout  = dat_p2;
            assign rd_valid = vld_p2;
        end else begin : g_no_out_reg
            assign rd_dout  = dat_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: two instances (16-deep latency 1, 4-deep latency 2) share one stimulus
// stream; a loader model supplies expected status and memory contents for a read scoreboard.
module tb_prog_mem_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_last = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] ld_byte = 8'h00;
    logic [3:0] rd_addr = 4'h0;

    logic        ld_ready0, load_done0, rd_valid0;
    logic [4:0]  ld_words0;
    logic [15:0] rd_dout0;
    logic        ld_ready1, load_done1, rd_valid1;
    logic [2:0]  ld_words1;
    logic [15:0] rd_dout1;
    logic [6:0]  st0, st1;

    always #5 clk = ~clk;

    prog_mem_loader #(.DWIDTH(16), .AWIDTH(4), .DEPTH(16), .OUT_REG(0)) u0 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready0), .load_done(load_done0),
        .ld_words(ld_words0), .rd_en(rd_en), .rd_addr(rd_addr), .rd_dout(rd_dout0),
        .rd_valid(rd_valid0)
    );

    prog_mem_loader #(.DWIDTH(16), .AWIDTH(2), .DEPTH(4), .OUT_REG(1)) u1 (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .ld_valid(ld_valid),
        .ld_byte(ld_byte), .ld_last(ld_last), .ld_ready(ld_ready1), .load_done(load_done1),
        .ld_words(ld_words1), .rd_en(rd_en), .rd_addr(rd_addr[1:0]), .rd_dout(rd_dout1),
        .rd_valid(rd_valid1)
    );

    assign st0 = {ld_ready0, load_done0, ld_words0};
    assign st1 = {ld_ready1, load_done1, 2'b00, ld_words1};

    typedef struct {
        logic [15:0] data;
        int          due;
    } rd_item_t;

    rd_item_t q0[$];
    rd_item_t q1[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // loader model: state 0 idle, 1 load, 2 done
    int          ms[2];
    int          mcnt[2];
    int          mwp[2];
    int          mwords[2];
    logic [15:0] masm[2];
    logic [15:0] mmem[2][16];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic logic [6:0] exp_st(input int i);
        return {ms[i] == 1, ms[i] == 2, 5'(mwords[i])};
    endfunction

    // read scoreboard: pops on every rd_valid and checks both data and arrival cycle
    always @(negedge clk) begin : mon
        rd_item_t it;
        if (rd_valid0) begin
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL rd0_unexpected rd_valid=1 at cycle %0d required no read pending", cyc);
            end else begin
                it = q0.pop_front();
                if (cyc != it.due || (!$isunknown(it.data) && rd_dout0 !== it.data)) begin
                    errors++;
                    $display("FAIL rd0_data got %h at cycle %0d required %h at cycle %0d",
                             rd_dout0, cyc, it.data, it.due);
                end
            end
        end
        if (rd_valid1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL rd1_unexpected rd_valid=1 at cycle %0d required no read pending", cyc);
            end else begin
                it = q1.pop_front();
                if (cyc != it.due || (!$isunknown(it.data) && rd_dout1 !== it.data)) begin
                    errors++;
                    $display("FAIL rd1_data got %h at cycle %0d required %h at cycle %0d",
                             rd_dout1, cyc, it.data, it.due);
                end
            end
        end
    end

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            ms[i] = 0; mcnt[i] = 0; mwp[i] = 0; mwords[i] = 0; masm[i] = 16'h0000;
        end
    endtask

    task automatic do_start();
        load_start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            ms[i] = 1; mcnt[i] = 0; mwp[i] = 0; mwords[i] = 0; masm[i] = 16'h0000;
        end
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic do_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1; ld_byte = b; ld_last = last;
        for (int i = 0; i < 2; i++) begin
            if (ms[i] == 1) begin
                masm[i][8*mcnt[i] +: 8] = b;
                if (mcnt[i] == 1 || last) begin
                    mmem[i][mwp[i]] = masm[i];
                    mwp[i]++; mwords[i]++;
                    masm[i] = 16'h0000; mcnt[i] = 0;
                    if (last || mwp[i] == dep(i)) ms[i] = 2;
                end else begin
                    mcnt[i]++;
                end
            end
        end
        @(negedge clk);
        ld_valid = 1'b0; ld_last = 1'b0;
    endtask

    task automatic rd_issue(input logic [3:0] a);
        rd_en = 1'b1; rd_addr = a;
        if (ms[0] != 1) q0.push_back('{mmem[0][a], cyc + 1});
        if (ms[1] != 1) q1.push_back('{mmem[1][a[1:0]], cyc + 2});
        @(negedge clk);
    endtask

    task automatic drain();
        for (int k = 0; k < 8 && (q0.size() != 0 || q1.size() != 0); k++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL read_drain pending %0d/%0d required 0/0", q0.size(), q1.size());
            q0.delete(); q1.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; m_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if ({st0, st1} !== 14'h0) begin
            errors++; $display("FAIL reset_status got %h/%h required 00/00", st0, st1);
        end
        checks++;
        if ({rd_valid0, rd_valid1, rd_dout0, rd_dout1} !== 34'h0) begin
            errors++;
            $display("FAIL reset_read got v%b%b %h %h required v00 0000 0000",
                     rd_valid0, rd_valid1, rd_dout0, rd_dout1);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_idle_read();
        rd_issue(4'd0); rd_en = 1'b0;
        drain();
        checks++;
        if (st0 !== 7'h00 || st1 !== 7'h00) begin
            errors++; $display("FAIL idle_status got %h/%h required 00/00", st0, st1);
        end
    endtask

    task automatic test_load_basic();
        do_start();
        checks++;
        if (st0 !== 7'b1000000 || st1 !== 7'b1000000) begin
            errors++; $display("FAIL basic_start got %h/%h required 40/40", st0, st1);
        end
        do_byte(8'h04, 1'b0); do_byte(8'h00, 1'b0); do_byte(8'h00, 1'b0); do_byte(8'h34, 1'b1);
        checks++;
        if (st0 !== 7'b0100010 || st1 !== 7'b0100010) begin
            errors++; $display("FAIL basic_done got %h/%h required 22/22", st0, st1);
        end
        rd_issue(4'd1); rd_issue(4'd0); rd_en = 1'b0;
        drain();
    endtask

    task automatic test_odd_count();
        do_start();
        do_byte(8'hAA, 1'b0); do_byte(8'hBB, 1'b0); do_byte(8'hCC, 1'b1);
        checks++;
        if (st0 !== 7'b0100010 || st1 !== 7'b0100010) begin
            errors++; $display("FAIL odd_done got %h/%h required 22/22", st0, st1);
        end
        rd_issue(4'd0); rd_en = 1'b0;
        rd_issue(4'd1); rd_en = 1'b0;
        drain();
    endtask

    task automatic test_depth_limit();
        logic seen;
        do_start();
        rd_issue(4'd2); rd_en = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            seen = seen | rd_valid0 | rd_valid1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("FAIL load_read_blocked got rd_valid=%b required 0", seen);
        end
        for (int b = 0; b < 8; b++) do_byte(8'(8'h10 + b), 1'b0);
        checks++;
        if (st1 !== 7'b0100100 || st0 !== 7'b1000100) begin
            errors++; $display("FAIL depth_full got %h/%h required 44/24", st0, st1);
        end
        do_byte(8'h18, 1'b0); do_byte(8'h19, 1'b0);
        checks++;
        if (st1 !== 7'b0100100 || st0 !== 7'b1000101) begin
            errors++; $display("FAIL depth_ignore got %h/%h required 45/24", st0, st1);
        end
        do_byte(8'h1A, 1'b1);
        checks++;
        if (st0 !== exp_st(0) || st0 !== 7'b0100110) begin
            errors++; $display("FAIL depth_u0_done got %h required 26", st0);
        end
    endtask

    task automatic test_back_to_back();
        for (int a = 0; a < 6; a++) rd_issue(4'(a));
        for (int a = 5; a >= 0; a--) rd_issue(4'(a));
        rd_en = 1'b0;
        drain();
    endtask

    task automatic test_reset_midload();
        do_start();
        do_byte(8'h01, 1'b0); do_byte(8'h02, 1'b0); do_byte(8'h03, 1'b0);
        checks++;
        if (st0 !== 7'b1000001 || st1 !== 7'b1000001) begin
            errors++; $display("FAIL midload_status got %h/%h required 41/41", st0, st1);
        end
        rst_n = 1'b0; m_reset();
        #1;
        checks++;
        if (st0 !== 7'h00 || st1 !== 7'h00) begin
            errors++; $display("FAIL midload_reset got %h/%h required 00/00", st0, st1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rd_issue(4'd0); rd_en = 1'b0;
        rd_issue(4'd1); rd_en = 1'b0;
        drain();
    endtask

    task automatic test_restart();
        do_start();
        do_byte(8'h55, 1'b0); do_byte(8'h66, 1'b0); do_byte(8'h77, 1'b0);
        do_start();
        checks++;
        if (st0 !== 7'b1000000 || st1 !== 7'b1000000) begin
            errors++; $display("FAIL restart_status got %h/%h required 40/40", st0, st1);
        end
        do_byte(8'h88, 1'b0); do_byte(8'h99, 1'b1);
        checks++;
        if (st0 !== 7'b0100001 || st1 !== 7'b0100001) begin
            errors++; $display("FAIL restart_done got %h/%h required 21/21", st0, st1);
        end
        rd_issue(4'd0); rd_issue(4'd1); rd_en = 1'b0;
        drain();
    endtask

    initial begin
        m_reset();
        test_reset();
        test_idle_read();
        test_load_basic();
        test_odd_count();
        test_depth_limit();
        test_back_to_back();
        test_reset_midload();
        test_restart();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout bench still running at cycle %0d required completion", cyc);
        $fatal(1, "timeout");
    end

endmodule
